// File: rtl/fir_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the FIR lane array.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

  localparam int DEF_LANES  = 64;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_TAPS   = 8;
  localparam int DEF_SHIFT  = 15;

  // Wide enough for any sensible accumulator plus the rounding offset.
  localparam int CALC_W = 64;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Bits needed to hold the sum of TAPS full-precision products.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Round half up, arithmetic right shift, then clamp to a signed data_w range.
  function automatic logic signed [CALC_W-1:0] round_sat(
    input logic signed [CALC_W-1:0] acc,
    input int                       shift,
    input int                       data_w
  );
    logic signed [CALC_W-1:0] r;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    r  = (acc + (CALC_W'(1) <<< (shift - 1))) >>> shift;
    hi = (CALC_W'(1) <<< (data_w - 1)) - CALC_W'(1);
    lo = -(CALC_W'(1) <<< (data_w - 1));
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_lane.sv
// One FIR channel: delay line, registered products, then sum/round/saturate.
// Latency: product register on accept, output register on the following advance.
// Backpressure: everything holds when advance is low; flush clears the history.
module fir_lane
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   accept,
  input  logic                   advance,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      x,
  input  logic [TAPS*COEF_W-1:0] coef,
  output logic [DATA_W-1:0]      y
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

  // dl[k] is the sample k+1 positions older than the one being accepted.
  logic signed [DATA_W-1:0] dl     [TAPS-1];
  logic signed [PROD_W-1:0] prod   [TAPS];
  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic signed [ACC_W-1:0]  acc;

  // Products for the incoming sample: tap 0 sees x, tap k sees the sample k-1 deep in the line
  always_comb begin
    prod_d[0] = PROD_W'($signed(x)) * PROD_W'($signed(coef[0 +: COEF_W]));
    for (int k = 1; k < TAPS; k++) begin
      prod_d[k] = PROD_W'(dl[k-1]) * PROD_W'($signed(coef[k*COEF_W +: COEF_W]));
    end
  end

  // Delay line and product registers move only when a new sample is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS - 1; k++) dl[k] <= '0;
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < TAPS - 1; k++) dl[k] <= '0;
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
    end else if (accept) begin
      dl[0] <= x;
      for (int k = 1; k < TAPS - 1; k++) dl[k] <= dl[k-1];
      for (int k = 0; k < TAPS; k++) prod[k] <= prod_d[k];
    end
  end

  // Full-precision sum of the registered products
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc = acc + ACC_W'(prod[k]);
    end
  end

  // Output register: round and saturate, hold while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (advance) begin
      y <= DATA_W'(round_sat(CALC_W'(acc), SHIFT, DATA_W));
    end
  end

endmodule

// File: rtl/fir_filter_array.sv
// LANES lockstep FIR channels sharing one run-time loaded coefficient bank.
// Latency: result valid two cycles after the accept cycle, one vector per cycle.
// Backpressure: out_ready low freezes both stages; in_ready drops during stalls, coef writes and flush.
module fir_filter_array
  import fir_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       coef_wr,
  input  logic [$clog2(TAPS)-1:0]    coef_idx,
  input  logic [COEF_W-1:0]          coef_data,
  output logic                       coef_ok,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_W-1:0]    in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DATA_W-1:0]    out_data
);

  state_t                 state_q;
  state_t                 state_d;
  logic [TAPS-1:0]        wr_mask;
  logic [TAPS*COEF_W-1:0] coef_bank;
  logic                   idx_ok;
  logic                   advance;
  logic                   accept;
  logic                   s1_vld;

  // Non-power-of-two TAPS leaves unused index codes; those writes are dropped.
  assign idx_ok = 32'(coef_idx) < 32'(TAPS);

  // Coefficient bank and written mask; a write lands at the next edge in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_bank <= '0;
      wr_mask   <= '0;
    end else if (coef_wr && idx_ok) begin
      coef_bank[int'(coef_idx)*COEF_W +: COEF_W] <= coef_data;
      wr_mask[coef_idx]                          <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave IDLE once every tap has been written; RUN is sticky until reset
  always_comb begin
    state_d = state_q;
    coef_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (&wr_mask) state_d = RUN;
      end
      RUN: begin
        coef_ok = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A sample never straddles a coefficient update and flush always wins over accept.
  assign advance  = !out_valid || out_ready;
  assign in_ready = coef_ok && advance && !coef_wr && !flush;
  assign accept   = in_valid && in_ready;

  // Stage-1 and output valid flags; refilled in the same edge the output is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_vld    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_vld <= 1'b1;
      end else if (advance) begin
        s1_vld <= 1'b0;
      end
      if (advance) begin
        out_valid <= s1_vld;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fir_lane #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .TAPS   (TAPS),
      .SHIFT  (SHIFT)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .accept  (accept),
      .advance (advance),
      .flush   (flush),
      .x       (in_data[i*DATA_W +: DATA_W]),
      .coef    (coef_bank),
      .y       (out_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_fir_filter_array.sv
module tb_fir_filter_array;

  localparam int L  = 4;
  localparam int DW = 24;
  localparam int CW = 16;
  localparam int T  = 4;
  localparam int SH = 15;

  typedef logic [L-1:0][DW-1:0] vec_t;
  typedef struct packed {
    vec_t x;
    vec_t y;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          coef_wr;
  logic [1:0]    coef_idx;
  logic [CW-1:0] coef_data;
  logic          coef_ok;
  logic          in_valid;
  logic          in_ready;
  vec_t          in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  vec_t          out_data;

  fir_filter_array #(
    .LANES (L), .DATA_W (DW), .COEF_W (CW), .TAPS (T), .SHIFT (SH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coef_wr   (coef_wr),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .coef_ok   (coef_ok),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  rec_t tbl [8];
  int   rc [4];
  vec_t got [$];
  int   got_cyc [$];
  int   acc_cyc [$];
  logic stall_q = 1'b0;
  vec_t held;
  int   stall_viol = 0;
  bit   rnd_on = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint lane_of(input vec_t v, input int i);
    return longint'($signed(v[i]));
  endfunction

  function automatic vec_t v4(input int a0, input int a1, input int a2, input int a3);
    vec_t v;
    v[0] = DW'(a0); v[1] = DW'(a1); v[2] = DW'(a2); v[3] = DW'(a3);
    return v;
  endfunction

  // Ramp stimulus: lanes 0..2 rise at different slopes, lane 3 falls.
  function automatic int xin(input int l, input int n);
    if (n < 1) return 0;
    return (l == 3) ? -3 * n : n * (l + 1);
  endfunction

  // Direct-form reference: sum c[k]*x[n-k], round half up, clamp.
  function automatic longint ref_y(input int l, input int n);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < T; k++) acc += longint'(rc[k]) * longint'(xin(l, n - k));
    r = (acc + (64'sd1 <<< (SH - 1))) >>> SH;
    if (r > 8388607) r = 8388607;
    if (r < -8388608) r = -8388608;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Negedge monitor: records transfers and accepts, checks output hold during stalls
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q && !(out_valid && out_data == held)) stall_viol++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      stall_q = out_valid && !out_ready && !flush;
      held    = out_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int val);
    coef_wr   = 1'b1;
    coef_idx  = 2'(idx);
    coef_data = CW'(val);
    tick();
    coef_wr   = 1'b0;
  endtask

  task automatic load(input int c0, input int c1, input int c2, input int c3);
    wr(0, c0); wr(1, c1); wr(2, c2); wr(3, c3);
    tick();
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic send(input vec_t v);
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    in_data  = v;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accept", longint'(ok), 1);
  endtask

  task automatic drain(input int n);
    for (int w = 0; w < 500 && got.size() < n; w++) tick();
    check("drain_count", got.size(), n);
  endtask

  task automatic run_table(input int first, input int n);
    got.delete(); got_cyc.delete(); acc_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) send(tbl[first+i].x);
    drain(n);
    for (int i = 0; i < n && i < got.size(); i++)
      for (int l = 0; l < L; l++)
        check($sformatf("tbl%0d_lane%0d", first + i, l),
              lane_of(got[i], l), lane_of(tbl[first+i].y, l));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hi_ok;
    int hi_rdy;
    vec_t v;

    // Impulse through c = {8192, 16384, -8192, 0}; lanes 2 and 3 probe rounding at .5
    tbl[0].x = v4(4000, -4000, 2, 4); tbl[0].y = v4(1000, -1000, 1, 1);
    tbl[1].x = v4(0, 0, 0, 0);        tbl[1].y = v4(2000, -2000, 1, 2);
    tbl[2].x = v4(0, 0, 0, 0);        tbl[2].y = v4(-1000, 1000, 0, -1);
    tbl[3].x = v4(0, 0, 0, 0);        tbl[3].y = v4(0, 0, 0, 0);
    // All taps 32767: first sample is just below full scale, later ones clamp
    tbl[4].x = v4(8388607, -8388608, 8388607, -8388608);
    tbl[4].y = v4(8388351, -8388352, 8388351, -8388352);
    for (int i = 5; i < 8; i++) begin
      tbl[i].x = v4(8388607, -8388608, 8388607, -8388608);
      tbl[i].y = v4(8388607, -8388608, 8388607, -8388608);
    end
    rc = '{12000, -7000, 3000, 20000};

    rst_n = 1'b0; coef_wr = 1'b0; coef_idx = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data == '0), 1);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_coef_ok", longint'(coef_ok), 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_coef_ok", longint'(coef_ok), 0);

    // Incomplete load keeps the block closed
    wr(0, 8192); wr(1, 16384); wr(2, -8192);
    in_valid = 1'b1; in_data = v4(1, 1, 1, 1);
    hi_ok = 0; hi_rdy = 0;
    repeat (20) begin
      @(negedge clk);
      if (coef_ok) hi_ok++;
      if (in_ready) hi_rdy++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("incomplete_coef_ok", hi_ok, 0);
    check("incomplete_in_ready", hi_rdy, 0);
    check("incomplete_out_valid", longint'(out_valid), 0);
    wr(3, 0);
    check("last_write_+1_coef_ok", longint'(coef_ok), 0);
    tick();
    check("last_write_+2_coef_ok", longint'(coef_ok), 1);
    check("last_write_+2_in_ready", longint'(in_ready), 1);

    // Impulse response and timing
    run_table(0, 4);
    if (got_cyc.size() >= 4 && acc_cyc.size() >= 1) begin
      check("impulse_latency", got_cyc[0] - acc_cyc[0], 2);
      check("impulse_consecutive", got_cyc[3] - got_cyc[0], 3);
    end

    // Flush with both stages full, then flush against a simultaneous offer
    out_ready = 1'b0;
    send(v4(4000, 4000, 0, 0));
    send(v4(4000, 4000, 0, 0));
    check("preflush_out_valid", longint'(out_valid), 1);
    do_flush();
    check("flush_out_valid", longint'(out_valid), 0);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = v4(4000, 0, 0, 0);
    #1;
    check("flush_in_ready", longint'(in_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("flush_no_accept", longint'(out_valid), 0);
    run_table(0, 4);

    // Saturation
    load(32767, 32767, 32767, 32767);
    do_flush();
    run_table(4, 4);

    // Ramp under random backpressure against the reference model
    load(rc[0], rc[1], rc[2], rc[3]);
    do_flush();
    got.delete(); got_cyc.delete(); acc_cyc.delete();
    rnd_on = 1;
    for (int n = 1; n <= 100; n++) begin
      for (int l = 0; l < L; l++) v[l] = DW'(xin(l, n));
      send(v);
    end
    drain(100);
    rnd_on = 0;
    tick(); tick();
    out_ready = 1'b1;
    for (int n = 1; n <= 100 && n <= got.size(); n++)
      for (int l = 0; l < L; l++)
        check($sformatf("ramp%0d_lane%0d", n, l), lane_of(got[n-1], l), ref_y(l, n));

    // Reset in the middle of a cycle while holding a result
    out_ready = 1'b0;
    send(v4(4000, 4000, 4000, 4000));
    send(v4(4000, 4000, 4000, 4000));
    check("prereset_out_valid", longint'(out_valid), 1);
    check("prereset_out_data_nonzero", longint'(out_data != '0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    for (int l = 0; l < L; l++) check($sformatf("midrst_lane%0d", l), lane_of(out_data, l), 0);
    check("midrst_in_ready", longint'(in_ready), 0);
    check("midrst_coef_ok", longint'(coef_ok), 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("after_rst_coef_ok", longint'(coef_ok), 0);
    wr(0, 8192); wr(1, 16384); wr(2, -8192);
    tick();
    check("after_rst_partial_coef_ok", longint'(coef_ok), 0);
    wr(3, 0);
    tick();
    check("after_rst_full_coef_ok", longint'(coef_ok), 1);
    run_table(0, 4);

    check("stall_stable", stall_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
